sd_dma_arbiter: RTL and testbench
=================================

// Module: sd_dma_arbiter
// PURPOSE
//  Shares the single SD wishbone DMA engine (sd_wishbone) between two block-transfer requesters.
//  Each requester is, for example, the card manager and a host-side prefetcher.
//  Picks one request at a time (round-robin) and drives the engine's edge-triggered act/addr handshake.
//  Holds the read BRAM until the winning requester releases it, then enforces an idle gap before the next job.
//  Sits between the requesters and sd_wishbone. All signals are in the clk_50 domain.
// PARAMETERS
//  GAP_CYCLES      2      cycles both ext_*_act held low between jobs (min 2; engine edge-detects act)
//  TIMEOUT_CYCLES  65536  watchdog limit per job (used only with SD_DMA_ARB_TIMEOUT_EN)
// PORTS
//  clk_50          in   1   clock; clocks every register in the block
//  reset_n         in   1   reset, asynchronous, active-low
//  req_valid       in   2   per-port request; held until matching grant pulse
//  req_write       in   2   per-port direction: 1 = write to wishbone, 0 = read into BRAM
//  req_addr        in   64  per-port 512-byte block address; port i uses bits [32i+31:32i]
//  req_grant       out  2   1-cycle pulse: request accepted, address latched
//  req_rd_ready    out  2   level: read data valid in BRAM for granted port
//  req_rd_release  in   2   pulse from granted port: BRAM consumed
//  req_done        out  2   1-cycle pulse: job complete
//  req_err         out  2   1-cycle pulse: job aborted by watchdog (0 without macro)
//  ext_read_act    out  1   to engine: start read (held through job)
//  ext_read_addr   out  32  to engine: read block address
//  ext_read_go     in   1   from engine: BRAM filled
//  ext_read_stop   out  1   to engine: 1-cycle release pulse
//  ext_write_act   out  1   to engine: start write (held through job)
//  ext_write_addr  out  32  to engine: write block address
//  ext_write_done  in   1   from engine: sticky level; stays high until next write starts
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, state=IDLE, last_served=1 (port 0 wins first tie).
//  States: IDLE, RD_ACT, RD_HOLD, WR_ACT, GAP.
//  IDLE:
//   - one valid port wins; both valid -> the port != last_served wins.
//   - Same cycle: req_grant[win]=1; latch port, dir, addr into owner/ext_*_addr; last_served<=win.
//   - Next state RD_ACT or WR_ACT.
//   - ext_*_addr holds its value outside jobs.
//  RD_ACT:
//   - ext_read_act=1 from the cycle after grant.
//   - On ext_read_go=1: req_rd_ready[owner]<=1 -> RD_HOLD.
//  RD_HOLD:
//   - req_rd_release[owner]=1 -> ext_read_stop=1 for 1 cycle.
//   - Same edge: ext_read_act<=0, req_rd_ready<=0, req_done[owner]=1 pulse -> GAP.
//   - Release from the non-owner port is ignored.
//  WR_ACT:
//   - ext_write_act=1.
//   - Completion only on a rising edge of ext_write_done (registered copy was 0, now 1).
//   - A stale high level from the previous write never completes the job.
//   - On the edge: ext_write_act<=0, req_done[owner] pulse -> GAP.
//  GAP:
//   - counter counts GAP_CYCLES with both acts low, then -> IDLE.
//   - Requests are not granted during GAP.
//  Latency:
//   - grant -> act: 1 cycle.
//   - go -> rd_ready: 1 cycle.
//   - release -> stop/done: 1 cycle.
//   - write_done edge -> done: 1 cycle (edge detected on registered input).
//  Requester holding valid after grant: re-arbitrated as a new job after GAP.
//  Never both ext_read_act and ext_write_act high. At most one req_grant/req_done bit set per cycle.
//  reset_n low mid-job: async clear to reset values. The engine shares the reset; no stop or done is issued.
// CONFIGURATION
//  SD_DMA_ARB_TIMEOUT_EN defined:
//   - 17-bit watchdog clears on entering RD_ACT/WR_ACT; counts in RD_ACT, RD_HOLD, WR_ACT.
//   - Reaching TIMEOUT_CYCLES: req_err[owner] pulse; no req_done; drop act.
//   - In RD_ACT/RD_HOLD, also pulse ext_read_stop. Then clear rd_ready -> GAP.
//  Undefined:
//   - no counter; req_err tied 0; jobs wait indefinitely.
// TESTING
//  1. req_valid=01, write=0, addr0=0x10:
//     - grant=01, then ext_read_act=1 with ext_read_addr=0x10.
//     - go=1 -> rd_ready=01; release=01 -> stop pulse, act=0, done=01.
//     - act low for 2 cycles.
//  2. From reset, req_valid=11, both reads:
//     - port0 granted, then port1 after port0 done + GAP.
//     - Repeat with both valid -> port0 again (alternates).
//  3. Port1 write addr 0x200, ext_write_done held 1 from prior job:
//     - no done while it stays 1.
//     - done drops to 0, then rises -> done=10, ext_write_act=0.
//  4. TIMEOUT_CYCLES=64, macro on, read with go never asserted:
//     - err=01 on cycle 64 after act, plus stop pulse; no done; next request is granted after GAP.
//  5. reset_n low during RD_HOLD:
//     - all outputs 0 immediately (async).
//     - After release, a pending port1 request is granted first (last_served=1 rule).
//  6. Read in RD_HOLD, req_rd_release=10 from non-owner: ignored, rd_ready stays 01.

Source files
------------

// File: rtl/sd_dma_arbiter.sv
// sd_dma_arbiter: round-robin share of the single SD wishbone DMA engine
// between two block-transfer requesters. Drives the engine's edge-triggered
// act/addr handshake, holds the read BRAM until the owner releases it, and
// keeps both acts low for GAP_CYCLES between jobs so the engine sees a fresh edge.
// Optional watchdog: define SD_DMA_ARB_TIMEOUT_EN to abort jobs after
// TIMEOUT_CYCLES; otherwise jobs wait indefinitely and req_err stays 0.
//
// state   | meaning
// IDLE    | no job; arbitrate and grant in the same cycle
// RD_ACT  | read act high, waiting for ext_read_go
// RD_HOLD | BRAM valid for owner, waiting for owner's release
// WR_ACT  | write act high, waiting for a rising edge of ext_write_done
// GAP     | both acts low for GAP_CYCLES before the next grant
module sd_dma_arbiter #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    output logic [1:0]  req_grant,
    output logic [1:0]  req_rd_ready,
    input  logic [1:0]  req_rd_release,
    output logic [1:0]  req_done,
    output logic [1:0]  req_err,
    output logic        ext_read_act,
    output logic [31:0] ext_read_addr,
    input  logic        ext_read_go,
    output logic        ext_read_stop,
    output logic        ext_write_act,
    output logic [31:0] ext_write_addr,
    input  logic        ext_write_done
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_RD_ACT, ST_RD_HOLD, ST_WR_ACT, ST_GAP} state_t;

    state_t          state, state_nxt;
    logic            owner;
    logic            last_served;
    logic            win;
    logic            wr_done_q;
    logic            wr_rise;
    logic            release_hit;
    logic            timeout_hit;
    logic [GW-1:0]   gap_cnt;

    // On a tie the port that was not served last wins
    assign win         = (req_valid == 2'b11) ? ~last_served : req_valid[1];
    // Completion needs a real 0->1 transition so a stale sticky level is ignored
    assign wr_rise     = ext_write_done & ~wr_done_q;
    assign release_hit = req_rd_release[owner];

`ifdef SD_DMA_ARB_TIMEOUT_EN
    logic [16:0] wd_cnt;

    // Watchdog: cleared while idle/gapping, so every job starts from zero
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n)
            wd_cnt <= '0;
        else if (state == ST_IDLE || state == ST_GAP)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 17'd1;
    end

    assign timeout_hit = (state == ST_RD_ACT || state == ST_RD_HOLD || state == ST_WR_ACT) &&
                         (wd_cnt == 17'(TIMEOUT_CYCLES - 1));

    // Error pulse to the owner on the cycle after the watchdog expires
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n)
            req_err <= '0;
        else
            req_err <= timeout_hit ? (owner ? 2'b10 : 2'b01) : 2'b00;
    end
`else
    assign timeout_hit = 1'b0;
    assign req_err     = 2'b00;
`endif

    // State register
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and the combinational grant pulse (suppressed while in reset)
    always_comb begin
        state_nxt = state;
        req_grant = 2'b00;
        case (state)
            ST_IDLE: begin
                if (reset_n && (req_valid != 2'b00)) begin
                    req_grant[win] = 1'b1;
                    state_nxt      = req_write[win] ? ST_WR_ACT : ST_RD_ACT;
                end
            end
            ST_RD_ACT: begin
                if (timeout_hit)      state_nxt = ST_GAP;
                else if (ext_read_go) state_nxt = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                if (timeout_hit || release_hit) state_nxt = ST_GAP;
            end
            ST_WR_ACT: begin
                if (timeout_hit || wr_rise) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Job datapath: ownership, engine handshake, requester status pulses
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            owner          <= 1'b0;
            last_served    <= 1'b1;
            wr_done_q      <= 1'b0;
            gap_cnt        <= '0;
            req_rd_ready   <= '0;
            req_done       <= '0;
            ext_read_act   <= 1'b0;
            ext_read_addr  <= '0;
            ext_read_stop  <= 1'b0;
            ext_write_act  <= 1'b0;
            ext_write_addr <= '0;
        end else begin
            wr_done_q     <= ext_write_done;
            req_done      <= '0;
            ext_read_stop <= 1'b0;
            if (state != ST_GAP && state_nxt == ST_GAP)
                gap_cnt <= GW'(GAP_CYCLES - 1);
            case (state)
                ST_IDLE: begin
                    if (req_valid != 2'b00) begin
                        owner       <= win;
                        last_served <= win;
                        if (req_write[win]) begin
                            ext_write_addr <= win ? req_addr[63:32] : req_addr[31:0];
                            ext_write_act  <= 1'b1;
                        end else begin
                            ext_read_addr <= win ? req_addr[63:32] : req_addr[31:0];
                            ext_read_act  <= 1'b1;
                        end
                    end
                end
                ST_RD_ACT: begin
                    if (timeout_hit) begin
                        ext_read_act  <= 1'b0;
                        ext_read_stop <= 1'b1;
                    end else if (ext_read_go) begin
                        req_rd_ready[owner] <= 1'b1;
                    end
                end
                ST_RD_HOLD: begin
                    if (timeout_hit || release_hit) begin
                        ext_read_act  <= 1'b0;
                        ext_read_stop <= 1'b1;
                        req_rd_ready  <= '0;
                        if (!timeout_hit) req_done[owner] <= 1'b1;
                    end
                end
                ST_WR_ACT: begin
                    if (timeout_hit || wr_rise) begin
                        ext_write_act <= 1'b0;
                        if (!timeout_hit) req_done[owner] <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dma_arbiter.sv
// Directed bench for sd_dma_arbiter: inputs change on the falling edge,
// outputs are checked on the falling edge (or #1 after an input change for
// the combinational grant).
module tb_sd_dma_arbiter;
    localparam int TB_TIMEOUT = 64;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid, req_write, req_rd_release;
    logic [63:0] req_addr;
    logic [1:0]  req_grant, req_rd_ready, req_done, req_err;
    logic        ext_read_act, ext_read_go, ext_read_stop;
    logic        ext_write_act, ext_write_done;
    logic [31:0] ext_read_addr, ext_write_addr;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk_50 = ~clk_50;

    sd_dma_arbiter #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk_50(clk_50), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_grant(req_grant), .req_rd_ready(req_rd_ready),
        .req_rd_release(req_rd_release), .req_done(req_done), .req_err(req_err),
        .ext_read_act(ext_read_act), .ext_read_addr(ext_read_addr),
        .ext_read_go(ext_read_go), .ext_read_stop(ext_read_stop),
        .ext_write_act(ext_write_act), .ext_write_addr(ext_write_addr),
        .ext_write_done(ext_write_done)
    );

    task automatic apply_reset();
        reset_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
        req_rd_release = '0; ext_read_go = 1'b0; ext_write_done = 1'b0;
        repeat (2) @(negedge clk_50);
        reset_n = 1'b1;
    endtask

    // From a falling edge in RD_ACT: engine fills BRAM, then port p releases.
    // Returns at the falling edge of the done/stop cycle.
    task automatic finish_read(input int p);
        ext_read_go = 1'b1;
        @(negedge clk_50);
        ext_read_go = 1'b0;
        req_rd_release[p] = 1'b1;
        @(negedge clk_50);
        req_rd_release = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 2'b01; req_write = '0; req_addr = '0;
        req_rd_release = '0; ext_read_go = 1'b0; ext_write_done = 1'b0;
        #1;
        n_cmp++; if (req_grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b expected 00", req_grant); end
        req_valid = 2'b00;
        @(negedge clk_50); reset_n = 1'b1; @(negedge clk_50);
        n_cmp++;
        if ({req_grant, req_rd_ready, req_done, req_err, ext_read_act, ext_read_stop, ext_write_act,
             ext_read_addr, ext_write_addr} !== 75'd0) begin
            n_bad++; $display("FAIL reset_outputs: got grant=%b rdy=%b done=%b err=%b ract=%b stop=%b wact=%b expected all 0",
                              req_grant, req_rd_ready, req_done, req_err, ext_read_act, ext_read_stop, ext_write_act);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        req_valid = 2'b01; req_addr[31:0] = 32'h10; #1;
        n_cmp++; if (req_grant !== 2'b01) begin n_bad++; $display("FAIL rd_grant: got %b expected 01", req_grant); end
        n_cmp++; if (ext_read_act !== 1'b0) begin n_bad++; $display("FAIL rd_act_early: got %b expected 0", ext_read_act); end
        @(negedge clk_50); req_valid = 2'b00;
        n_cmp++; if (req_grant !== 2'b00) begin n_bad++; $display("FAIL rd_grant_pulse: got %b expected 00", req_grant); end
        n_cmp++; if ({ext_read_act, ext_read_addr} !== {1'b1, 32'h10}) begin n_bad++; $display("FAIL rd_act_addr: got act=%b addr=%h expected 1/00000010", ext_read_act, ext_read_addr); end
        ext_read_go = 1'b1; @(negedge clk_50); ext_read_go = 1'b0;
        n_cmp++; if (req_rd_ready !== 2'b01) begin n_bad++; $display("FAIL rd_ready: got %b expected 01", req_rd_ready); end
        req_rd_release = 2'b01; @(negedge clk_50); req_rd_release = 2'b00;
        n_cmp++; if ({ext_read_stop, req_done, ext_read_act, req_rd_ready} !== 6'b1_01_0_00) begin
            n_bad++; $display("FAIL rd_release: got stop=%b done=%b act=%b rdy=%b expected 1/01/0/00", ext_read_stop, req_done, ext_read_act, req_rd_ready); end
        @(negedge clk_50);
        n_cmp++; if ({ext_read_act, ext_read_stop, req_done} !== 4'b0) begin n_bad++; $display("FAIL rd_gap: got act=%b stop=%b done=%b expected 0/0/00", ext_read_act, ext_read_stop, req_done); end
        @(negedge clk_50);
        n_cmp++; if (ext_read_addr !== 32'h10) begin n_bad++; $display("FAIL rd_addr_hold: got %h expected 00000010", ext_read_addr); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_valid = 2'b11; req_write = 2'b00; req_addr = {32'h101, 32'h100}; #1;
        n_cmp++; if (req_grant !== 2'b01) begin n_bad++; $display("FAIL rr_first: got %b expected 01", req_grant); end
        @(negedge clk_50); req_valid = 2'b10;
        n_cmp++; if (ext_read_addr !== 32'h100) begin n_bad++; $display("FAIL rr_addr0: got %h expected 00000100", ext_read_addr); end
        finish_read(0);
        n_cmp++; if ({req_done, req_grant} !== 4'b01_00) begin n_bad++; $display("FAIL rr_done0: got done=%b grant=%b expected 01/00", req_done, req_grant); end
        @(negedge clk_50);
        n_cmp++; if (req_grant !== 2'b00) begin n_bad++; $display("FAIL rr_gap_nogrant: got %b expected 00", req_grant); end
        @(negedge clk_50);
        n_cmp++; if (req_grant !== 2'b10) begin n_bad++; $display("FAIL rr_second: got %b expected 10", req_grant); end
        @(negedge clk_50); req_valid = 2'b00;
        n_cmp++; if (ext_read_addr !== 32'h101) begin n_bad++; $display("FAIL rr_addr1: got %h expected 00000101", ext_read_addr); end
        finish_read(1);
        n_cmp++; if (req_done !== 2'b10) begin n_bad++; $display("FAIL rr_done1: got %b expected 10", req_done); end
        repeat (2) @(negedge clk_50);
        req_valid = 2'b11; #1;
        n_cmp++; if (req_grant !== 2'b01) begin n_bad++; $display("FAIL rr_alternate: got %b expected 01", req_grant); end
        @(negedge clk_50); req_valid = 2'b00;
        finish_read(0);
        repeat (2) @(negedge clk_50);
    endtask

    task automatic test_write_stale();
        apply_reset();
        ext_write_done = 1'b1;
        repeat (2) @(negedge clk_50);
        req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h200; #1;
        n_cmp++; if (req_grant !== 2'b10) begin n_bad++; $display("FAIL wr_grant: got %b expected 10", req_grant); end
        @(negedge clk_50); req_valid = 2'b00;
        n_cmp++; if ({ext_write_act, ext_read_act, ext_write_addr} !== {2'b10, 32'h200}) begin
            n_bad++; $display("FAIL wr_act_addr: got wact=%b ract=%b addr=%h expected 1/0/00000200", ext_write_act, ext_read_act, ext_write_addr); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50);
            n_cmp++; if ({req_done, ext_write_act} !== 3'b00_1) begin n_bad++; $display("FAIL wr_stale_%0d: got done=%b wact=%b expected 00/1", i, req_done, ext_write_act); end
        end
        ext_write_done = 1'b0; @(negedge clk_50);
        n_cmp++; if ({req_done, ext_write_act} !== 3'b00_1) begin n_bad++; $display("FAIL wr_low: got done=%b wact=%b expected 00/1", req_done, ext_write_act); end
        ext_write_done = 1'b1; @(negedge clk_50);
        n_cmp++; if ({req_done, ext_write_act} !== 3'b10_0) begin n_bad++; $display("FAIL wr_done: got done=%b wact=%b expected 10/0", req_done, ext_write_act); end
        repeat (2) @(negedge clk_50);
        n_cmp++; if ({ext_write_addr, ext_read_addr} !== {32'h200, 32'h0}) begin n_bad++; $display("FAIL wr_addr_hold: got w=%h r=%h expected 00000200/00000000", ext_write_addr, ext_read_addr); end
    endtask

    task automatic test_reset_mid_job();
        apply_reset();
        req_valid = 2'b01; req_addr = {32'h50, 32'h40};
        @(negedge clk_50); req_valid = 2'b00;
        ext_read_go = 1'b1; @(negedge clk_50); ext_read_go = 1'b0;
        req_valid = 2'b10;
        #2 reset_n = 1'b0; #1;
        n_cmp++;
        if ({req_grant, req_rd_ready, req_done, ext_read_act, ext_read_stop, ext_write_act, ext_read_addr} !== 41'd0) begin
            n_bad++; $display("FAIL async_reset: got grant=%b rdy=%b done=%b ract=%b stop=%b addr=%h expected all 0",
                              req_grant, req_rd_ready, req_done, ext_read_act, ext_read_stop, ext_read_addr); end
        @(negedge clk_50); reset_n = 1'b1; #1;
        n_cmp++; if (req_grant !== 2'b10) begin n_bad++; $display("FAIL post_reset_grant: got %b expected 10", req_grant); end
        @(negedge clk_50); req_valid = 2'b00;
        n_cmp++; if ({ext_read_act, ext_read_addr} !== {1'b1, 32'h50}) begin n_bad++; $display("FAIL post_reset_addr: got act=%b addr=%h expected 1/00000050", ext_read_act, ext_read_addr); end
        finish_read(1);
        repeat (2) @(negedge clk_50);
    endtask

    task automatic test_nonowner_release();
        apply_reset();
        req_valid = 2'b01; req_addr[31:0] = 32'h33;
        @(negedge clk_50); req_valid = 2'b00;
        ext_read_go = 1'b1; @(negedge clk_50); ext_read_go = 1'b0;
        req_rd_release = 2'b10; @(negedge clk_50); req_rd_release = 2'b00;
        n_cmp++; if ({req_rd_ready, req_done, ext_read_stop, ext_read_act} !== 6'b01_00_0_1) begin
            n_bad++; $display("FAIL nonowner_release: got rdy=%b done=%b stop=%b act=%b expected 01/00/0/1", req_rd_ready, req_done, ext_read_stop, ext_read_act); end
        req_rd_release = 2'b01; @(negedge clk_50); req_rd_release = 2'b00;
        n_cmp++; if (req_done !== 2'b01) begin n_bad++; $display("FAIL owner_release: got %b expected 01", req_done); end
        repeat (2) @(negedge clk_50);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req_valid = 2'b01; req_addr[31:0] = 32'h7;
        @(negedge clk_50);
        finish_read(0);
        n_cmp++; if (req_grant !== 2'b00) begin n_bad++; $display("FAIL b2b_gap1: got %b expected 00", req_grant); end
        @(negedge clk_50);
        n_cmp++; if (req_grant !== 2'b00) begin n_bad++; $display("FAIL b2b_gap2: got %b expected 00", req_grant); end
        @(negedge clk_50);
        n_cmp++; if (req_grant !== 2'b01) begin n_bad++; $display("FAIL b2b_regrant: got %b expected 01", req_grant); end
        @(negedge clk_50); req_valid = 2'b00;
        finish_read(0);
        repeat (2) @(negedge clk_50);
    endtask

`ifdef SD_DMA_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic early;
        early = 1'b0;
        apply_reset();
        req_valid = 2'b01; req_addr[31:0] = 32'h99; #1;
        n_cmp++; if (req_grant !== 2'b01) begin n_bad++; $display("FAIL to_grant: got %b expected 01", req_grant); end
        @(negedge clk_50); req_valid = 2'b00;
        for (int i = 2; i <= TB_TIMEOUT; i++) begin
            @(negedge clk_50);
            if (req_err !== 2'b00 || ext_read_act !== 1'b1) early = 1'b1;
        end
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL to_early: got err/act change before limit expected none"); end
        @(negedge clk_50);
        n_cmp++; if ({req_err, ext_read_stop, req_done, ext_read_act} !== 6'b01_1_00_0) begin
            n_bad++; $display("FAIL to_expire: got err=%b stop=%b done=%b act=%b expected 01/1/00/0", req_err, ext_read_stop, req_done, ext_read_act); end
        @(negedge clk_50); req_valid = 2'b10;
        @(negedge clk_50);
        n_cmp++; if (req_grant !== 2'b10) begin n_bad++; $display("FAIL to_next_grant: got %b expected 10", req_grant); end
        @(negedge clk_50); req_valid = 2'b00;
        finish_read(1);
        repeat (2) @(negedge clk_50);
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stale();
        test_reset_mid_job();
        test_nonowner_release();
        test_back_to_back();
`ifdef SD_DMA_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no completion expected finish before 200000 ns");
        $fatal(1, "simulation time limit");
    end

endmodule
